// File: rtl/tree_mult_pkg.sv
// Shared sizing helpers for the pipelined adder-tree multiplier.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package tree_mult_pkg;

    // Operand width limits the tree is meant to be built for.
    localparam int TM_MIN_WIDTH = 2;
    localparam int TM_MAX_WIDTH = 32;

    // Ceiling log2; tm_clog2(1) = 0, tm_clog2(8) = 3, tm_clog2(12) = 4.
    function automatic int tm_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of pairwise adder levels needed to reduce n partial products.
    function automatic int tm_levels(input int n);
        return tm_clog2(n);
    endfunction

    // Edges from acceptance to a valid product: partial-product bank plus one bank per level.
    function automatic int tm_lat(input int n);
        return tm_clog2(n) + 1;
    endfunction

endpackage

// File: rtl/tree_mult_level.sv
// One adder-tree level: sums NIN terms pairwise into NIN/2 registered terms.
// Latency: 1 cycle from in_dat_i to out_dat_o.
// Backpressure: data and valid load only when adv_i is high, otherwise the bank holds.
module tree_mult_level
    import tree_mult_pkg::*;
#(
    parameter int W   = 16,
    parameter int NIN = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    adv_i,
    input  logic                    in_vld_i,
    input  logic [NIN*W-1:0]        in_dat_i,
    output logic                    out_vld_o,
    output logic [(NIN/2)*W-1:0]    out_dat_o
);

    localparam int NOUT = NIN / 2;

    logic [NOUT*W-1:0] dat_d;
    logic [NOUT*W-1:0] dat_q;
    logic              vld_q;

    // Pairwise sums in W bits; carries out of the top bit are intentionally dropped.
    always_comb begin
        dat_d = '0;
        for (int j = 0; j < NOUT; j++) begin
            dat_d[j*W +: W] = in_dat_i[(2*j)*W +: W] + in_dat_i[(2*j+1)*W +: W];
        end
    end

    // Register bank with its travelling valid bit; frozen while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (adv_i) begin
            vld_q <= in_vld_i;
            dat_q <= dat_d;
        end
    end

    assign out_vld_o = vld_q;
    assign out_dat_o = dat_q;

endmodule

// File: rtl/param_tree_multiplier.sv
// Pipelined N x N -> 2N multiplier: input stage, partial-product bank, clog2(N) adder levels.
// Latency: LAT = clog2(N)+1 edges from acceptance to out_valid; one operation per cycle.
// Backpressure: whole pipe advances on out_ready || !out_valid; in_ready mirrors that enable.
// Optional MULT_SIGNED_EN adds a signed_mode port for per-operation two's-complement multiply.
module param_tree_multiplier
    import tree_mult_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     a_in,
    input  logic [DATA_WIDTH-1:0]     b_in,
`ifdef MULT_SIGNED_EN
    input  logic                      signed_mode,
`endif
    output logic [2*DATA_WIDTH-1:0]   p_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int W      = 2 * DATA_WIDTH;
    localparam int LEVELS = tm_levels(DATA_WIDTH);
    localparam int NT     = 1 << LEVELS;

    // Single advance enable shared by every stage.
    logic adv;

    // Input stage.
    logic                  in_vld_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
`ifdef MULT_SIGNED_EN
    logic                  sgn_q;
`endif

    // Partial-product stage, NT terms of W bits (terms at index >= N are always zero).
    logic [W-1:0]          a_ext;
    logic [NT*W-1:0]       pp_d;
    logic [NT*W-1:0]       pp_q;
    logic                  pp_vld_q;

    // Valid bit out of each adder level; the last one is the output stage.
    logic [LEVELS-1:0]     lvl_vld;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    // Capture an operand pair on acceptance; a cycle without in_valid shifts in a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
`ifdef MULT_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else if (adv) begin
            in_vld_q <= in_valid;
            if (in_valid) begin
                a_q   <= a_in;
                b_q   <= b_in;
`ifdef MULT_SIGNED_EN
                sgn_q <= signed_mode;
`endif
            end
        end
    end

    // Widen A to 2N bits: sign-extended for signed operations, zero-extended otherwise.
    always_comb begin
        a_ext = {{DATA_WIDTH{1'b0}}, a_q};
`ifdef MULT_SIGNED_EN
        if (sgn_q) begin
            a_ext = {{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q};
        end
`endif
    end

    // Shifted partial products; in signed mode the top multiplier bit carries negative weight.
    always_comb begin
        pp_d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (b_q[i]) begin
                pp_d[i*W +: W] = a_ext << i;
            end
        end
`ifdef MULT_SIGNED_EN
        if (sgn_q && b_q[DATA_WIDTH-1]) begin
            pp_d[(DATA_WIDTH-1)*W +: W] = -(a_ext << (DATA_WIDTH-1));
        end
`endif
    end

    // Partial-product register bank feeding the first adder level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pp_vld_q <= 1'b0;
            pp_q     <= '0;
        end else if (adv) begin
            pp_vld_q <= in_vld_q;
            pp_q     <= pp_d;
        end
    end

    // Adder tree: level l reduces NT>>l terms to NT>>(l+1) terms.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NIN = NT >> l;
        logic [(NIN/2)*W-1:0] dat;

        if (l == 0) begin : g_first
            tree_mult_level #(
                .W   (W),
                .NIN (NIN)
            ) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .adv_i     (adv),
                .in_vld_i  (pp_vld_q),
                .in_dat_i  (pp_q),
                .out_vld_o (lvl_vld[l]),
                .out_dat_o (dat)
            );
        end else begin : g_next
            tree_mult_level #(
                .W   (W),
                .NIN (NIN)
            ) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .adv_i     (adv),
                .in_vld_i  (lvl_vld[l-1]),
                .in_dat_i  (g_lvl[l-1].dat),
                .out_vld_o (lvl_vld[l]),
                .out_dat_o (dat)
            );
        end
    end

    // The last level's bank is the output stage.
    assign p_out     = g_lvl[LEVELS-1].dat;
    assign out_valid = lvl_vld[LEVELS-1];
    assign busy      = in_vld_q || pp_vld_q || (|lvl_vld);

endmodule

// File: tb/tb_param_tree_multiplier.sv
// Directed, table-driven bench for param_tree_multiplier at N=8 and N=12.
// Latency: checks LAT=4 (N=8) and LAT=5 (N=12) from acceptance to out_valid.
// Backpressure: exercises a mid-stream out_ready stall and a reset with operations in flight.
module tb_param_tree_multiplier;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
`ifdef MULT_SIGNED_EN
    logic        sm8;
    logic        sm12;
`endif

    logic        in_valid12, in_ready12, out_valid12, out_ready12, busy12;
    logic [11:0] a12, b12;
    logic [23:0] p12;

    int          errors;
    int          checks;
    int          cyc;

    logic [15:0] got_dat[$];
    int          got_cyc[$];

    vec_t        tbl[16];
`ifdef MULT_SIGNED_EN
    vec_t        stbl[7];
`endif

    param_tree_multiplier #(.DATA_WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a_in        (a8),
        .b_in        (b8),
`ifdef MULT_SIGNED_EN
        .signed_mode (sm8),
`endif
        .p_out       (p8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .busy        (busy8)
    );

    param_tree_multiplier #(.DATA_WIDTH(12)) u_dut12 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid12),
        .in_ready    (in_ready12),
        .a_in        (a12),
        .b_in        (b12),
`ifdef MULT_SIGNED_EN
        .signed_mode (sm12),
`endif
        .p_out       (p12),
        .out_valid   (out_valid12),
        .out_ready   (out_ready12),
        .busy        (busy12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every product transferred at the upcoming posedge (inputs are stable by negedge).
    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            got_dat.push_back(p8);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int w = 0; w < 40 && got_dat.size() < n; w++) tick();
    endtask

    initial begin
        int          lat_seen;
        logic [23:0] lat_p;
        int          idx;
        logic [15:0] held;
        logic        saw_valid;

        errors = 0; checks = 0; cyc = 0;
        tbl[0]  = '{8'd3,   8'd5,   1'b0, 16'd15};
        tbl[1]  = '{8'd0,   8'd200, 1'b0, 16'd0};
        tbl[2]  = '{8'd255, 8'd1,   1'b0, 16'd255};
        tbl[3]  = '{8'd1,   8'd255, 1'b0, 16'd255};
        tbl[4]  = '{8'd16,  8'd16,  1'b0, 16'd256};
        tbl[5]  = '{8'd100, 8'd100, 1'b0, 16'd10000};
        tbl[6]  = '{8'd200, 8'd3,   1'b0, 16'd600};
        tbl[7]  = '{8'd128, 8'd2,   1'b0, 16'd256};
        tbl[8]  = '{8'd15,  8'd15,  1'b0, 16'd225};
        tbl[9]  = '{8'd170, 8'd85,  1'b0, 16'd14450};
        tbl[10] = '{8'd85,  8'd170, 1'b0, 16'd14450};
        tbl[11] = '{8'd255, 8'd0,   1'b0, 16'd0};
        tbl[12] = '{8'd254, 8'd254, 1'b0, 16'd64516};
        tbl[13] = '{8'd12,  8'd34,  1'b0, 16'd408};
        tbl[14] = '{8'd99,  8'd201, 1'b0, 16'd19899};
        tbl[15] = '{8'd7,   8'd250, 1'b0, 16'd1750};
`ifdef MULT_SIGNED_EN
        stbl[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        stbl[1] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        stbl[2] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        stbl[3] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        stbl[4] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        stbl[5] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
        stbl[6] = '{8'hFE, 8'h03, 1'b1, 16'hFFFA};
        sm8 = 1'b0; sm12 = 1'b0;
`endif

        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
        in_valid12 = 1'b0; a12 = '0; b12 = '0; out_ready12 = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_busy",      32'(busy8),      32'd0);
        check("rst_p_out",     32'(p8),         32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(in_ready8),  32'd1);

        // 255*255 latency and value
        a8 = 8'd255; b8 = 8'd255; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat_seen = 0; lat_p = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 2) check("lat_busy", 32'(busy8), 32'd1);
            if (out_valid8 && lat_seen == 0) begin
                lat_seen = c;
                lat_p    = 24'(p8);
            end
        end
        check("lat8_cycles", 32'(lat_seen), 32'd4);
        check("lat8_prod",   32'(lat_p),    32'hFE01);
        check("idle_busy",   32'(busy8),    32'd0);

        // 16 back-to-back operations with out_ready high
        got_dat.delete(); got_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            a8 = tbl[i].a; b8 = tbl[i].b; in_valid8 = 1'b1;
            tick();
        end
        in_valid8 = 1'b0;
        drain(16);
        check("b2b_count", 32'(got_dat.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < got_dat.size()) check($sformatf("b2b[%0d]", i), 32'(got_dat[i]), 32'(tbl[i].exp));
        end
        if (got_cyc.size() == 16) check("b2b_consecutive", 32'(got_cyc[15] - got_cyc[0]), 32'd15);

        // Stream with a 3-cycle out_ready stall
        got_dat.delete(); got_cyc.delete();
        idx = 0; held = '0;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            out_ready8 = !(c >= 5 && c <= 7);
            a8 = tbl[idx].a; b8 = tbl[idx].b; in_valid8 = 1'b1;
            #1;
            if (c >= 5 && c <= 7) begin
                check("stall_in_ready", 32'(in_ready8),  32'd0);
                check("stall_valid",    32'(out_valid8), 32'd1);
                if (c == 5) held = p8;
                else check("stall_hold", 32'(p8), 32'(held));
            end
            if (in_ready8) idx++;
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        check("stall_held_val", 32'(held), 32'(tbl[0].exp));
        drain(8);
        check("stall_count", 32'(got_dat.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_dat.size()) check($sformatf("stall[%0d]", i), 32'(got_dat[i]), 32'(tbl[i].exp));
        end
        repeat (4) tick();

        // Reset with three operations in flight
        got_dat.delete(); got_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            a8 = tbl[i+4].a; b8 = tbl[i+4].b; in_valid8 = 1'b1;
            tick();
        end
        in_valid8 = 1'b0;
        tick();
        check("mid_busy_before_rst", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_out_valid", 32'(out_valid8), 32'd0);
        check("mid_rst_busy",      32'(busy8),      32'd0);
        check("mid_rst_p_out",     32'(p8),         32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(in_ready8),  32'd1);
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid8) saw_valid = 1'b1;
        end
        check("mid_rst_no_stale_valid", 32'(saw_valid),       32'd0);
        check("mid_rst_no_stale_out",   32'(got_dat.size()),  32'd0);

        // N=12 full-scale product and LAT=5
        a12 = 12'd4095; b12 = 12'd4095; in_valid12 = 1'b1;
        tick();
        in_valid12 = 1'b0;
        lat_seen = 0; lat_p = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (out_valid12 && lat_seen == 0) begin
                lat_seen = c;
                lat_p    = p12;
            end
        end
        check("lat12_cycles", 32'(lat_seen), 32'd5);
        check("lat12_prod",   32'(lat_p),    32'hFFE001);

`ifdef MULT_SIGNED_EN
        // Mixed signed/unsigned back-to-back traffic
        got_dat.delete(); got_cyc.delete();
        for (int i = 0; i < 7; i++) begin
            a8 = stbl[i].a; b8 = stbl[i].b; sm8 = stbl[i].sm; in_valid8 = 1'b1;
            tick();
        end
        in_valid8 = 1'b0; sm8 = 1'b0;
        drain(7);
        check("sgn_count", 32'(got_dat.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < got_dat.size()) check($sformatf("sgn[%0d]", i), 32'(got_dat[i]), 32'(stbl[i].exp));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
